custom_rv_core: RTL and testbench



---
 rtl/custom_rv_core.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_custom_rv_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_rv_core.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over two Wishbone classic masters.
// The register file lives in its own module so debug benches can reach regfile_inst.registers.
module custom_rv_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o
);
   logic [31:0] registers [0:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) registers[i] <= '0;
      end else if (we_i && waddr_i != 5'd0) begin
         registers[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : registers[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : registers[raddr2_i];
endmodule

module custom_rv_core #(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] iwb_adr_o,
   input  logic [31:0] iwb_dat_i,
   output logic        iwb_cyc_o,
   output logic        iwb_stb_o,
   input  logic        iwb_ack_i,
   output logic [31:0] dwb_adr_o,
   output logic [31:0] dwb_dat_o,
   input  logic [31:0] dwb_dat_i,
   output logic        dwb_we_o,
   output logic [3:0]  dwb_sel_o,
   output logic        dwb_cyc_o,
   output logic        dwb_stb_o,
   input  logic        dwb_ack_i,
   input  logic        dwb_err_i,
   input  logic [31:0] interrupts
);
   typedef enum logic [2:0] {
      FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEMORY = 3'd3, WRITEBACK = 3'd4
   } state_t;

   localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                          OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                          OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                          ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_OR = 4'd8, ALU_AND = 4'd9;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'd0, a < b};
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return a + b;
      endcase
   endfunction

   // Lane pick uses the low address bits; halves ignore addr[0] so misaligned halves truncate.
   function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(d >> {off, 3'b000});
      h = off[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return d;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, alu_res_q, alu_res_d;
   logic [31:0] next_pc_q, next_pc_d, load_q, load_d;
   logic        load_ok_q, load_ok_d, iwb_cyc_q, iwb_cyc_d, dwb_cyc_q, dwb_cyc_d;
   logic        dwb_we_q, dwb_we_d;
   logic [3:0]  dwb_sel_q, dwb_sel_d;
   logic [31:0] dwb_adr_q, dwb_adr_d, dwb_dat_q, dwb_dat_d;

   logic [2:0]  state;
   logic [31:0] pc, instruction, rs1_data, rs2_data, immediate;
   logic [31:0] alu_operand_a, alu_operand_b, alu_result, rd_data, pc_plus4, lane_dat;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [3:0]  alu_op, lane_sel;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        alu_src_imm, rd_wen, taken, unused_irq;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;

   assign state       = state_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign unused_irq  = ^interrupts;

   assign opcode   = instruction[6:0];
   assign funct3   = instruction[14:12];
   assign rd_addr  = instruction[11:7];
   assign rs1_addr = instruction[19:15];
   assign rs2_addr = instruction[24:20];
   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_op     = (opcode == OPC_OP);

   custom_rv_regfile regfile_inst (
      .clk      (clk),
      .rst_n    (rst_n),
      .raddr1_i (rs1_addr),
      .raddr2_i (rs2_addr),
      .we_i     (rd_wen),
      .waddr_i  (rd_addr),
      .wdata_i  (rd_data),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data)
   );

   always_comb begin
      immediate = 32'd0;
      case (opcode)
         OPC_OPIMM, OPC_LOAD, OPC_JALR:
            immediate = {{20{instruction[31]}}, instruction[31:20]};
         OPC_STORE:
            immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         OPC_BRANCH:
            immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            immediate = {instruction[31:12], 12'd0};
         OPC_JAL:
            immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
         default: immediate = 32'd0;
      endcase
   end

   always_comb begin
      alu_op = ALU_ADD;
      if (is_op || is_opimm) begin
         case (funct3)
            3'b000:  alu_op = (is_op && instruction[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = instruction[30] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
         endcase
      end
   end

   assign alu_src_imm   = is_opimm | is_load | is_store | is_lui | is_auipc | is_jal | is_jalr;
   assign alu_operand_a = (is_auipc || is_jal) ? pc : (is_lui ? 32'd0 : rs1_data);
   assign alu_operand_b = alu_src_imm ? immediate : rs2_data;
   assign alu_result    = alu_f(alu_op, alu_operand_a, alu_operand_b);
   assign pc_plus4      = pc + 32'd4;

   always_comb begin
      case (funct3)
         3'b000:  taken = (rs1_data == rs2_data);
         3'b001:  taken = (rs1_data != rs2_data);
         3'b100:  taken = ($signed(rs1_data) < $signed(rs2_data));
         3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  taken = (rs1_data < rs2_data);
         3'b111:  taken = (rs1_data >= rs2_data);
         default: taken = 1'b0;
      endcase
   end

   // funct3[1:0]: 00 byte, 01 half, otherwise word.
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            lane_sel = 4'b0001 << alu_result[1:0];
            lane_dat = {4{rs2_data[7:0]}};
         end
         2'b01: begin
            lane_sel = 4'b0011 << alu_result[1:0];
            lane_dat = {2{rs2_data[15:0]}};
         end
         default: begin
            lane_sel = 4'b1111;
            lane_dat = rs2_data;
         end
      endcase
   end

   assign rd_wen  = (state_q == WRITEBACK) &&
                    (is_op || is_opimm || is_lui || is_auipc || is_jal || is_jalr ||
                     (is_load && load_ok_q));
   assign rd_data = (is_jal || is_jalr) ? pc_plus4 : (is_load ? load_q : alu_res_q);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      alu_res_d = alu_res_q;
      next_pc_d = next_pc_q;
      load_d    = load_q;
      load_ok_d = load_ok_q;
      iwb_cyc_d = iwb_cyc_q;
      dwb_cyc_d = dwb_cyc_q;
      dwb_we_d  = dwb_we_q;
      dwb_sel_d = dwb_sel_q;
      dwb_adr_d = dwb_adr_q;
      dwb_dat_d = dwb_dat_q;
      case (state_q)
         FETCH: begin
            if (iwb_cyc_q && iwb_ack_i) begin
               instr_d   = iwb_dat_i;
               iwb_cyc_d = 1'b0;
               state_d   = DECODE;
            end else begin
               iwb_cyc_d = 1'b1;
            end
         end
         DECODE: state_d = EXECUTE;
         EXECUTE: begin
            alu_res_d = alu_result;
            if (is_jal)                   next_pc_d = alu_result;
            else if (is_jalr)             next_pc_d = alu_result & ~32'd1;
            else if (is_branch && taken)  next_pc_d = pc + immediate;
            else                          next_pc_d = pc_plus4;
            if (is_load || is_store) begin
               dwb_cyc_d = 1'b1;
               dwb_we_d  = is_store;
               dwb_sel_d = lane_sel;
               dwb_adr_d = funct3[1] ? {alu_result[31:2], 2'b00} : alu_result;
               dwb_dat_d = lane_dat;
               state_d   = MEMORY;
            end else begin
               state_d = WRITEBACK;
            end
         end
         MEMORY: begin
            if (dwb_cyc_q && (dwb_ack_i || dwb_err_i)) begin
               dwb_cyc_d = 1'b0;
               dwb_we_d  = 1'b0;
               dwb_sel_d = 4'b0000;
               load_d    = load_f(funct3, alu_res_q[1:0], dwb_dat_i);
               load_ok_d = !dwb_err_i;
               state_d   = WRITEBACK;
            end
         end
         WRITEBACK: begin
            pc_d      = next_pc_q;
            load_ok_d = 1'b0;
            iwb_cyc_d = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_VECTOR;
         load_ok_q <= 1'b0;
         iwb_cyc_q <= 1'b0;
         dwb_cyc_q <= 1'b0;
         dwb_we_q  <= 1'b0;
         dwb_sel_q <= 4'b0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         load_ok_q <= load_ok_d;
         iwb_cyc_q <= iwb_cyc_d;
         dwb_cyc_q <= dwb_cyc_d;
         dwb_we_q  <= dwb_we_d;
         dwb_sel_q <= dwb_sel_d;
      end
   end

   // Datapath holding registers carry no reset; they are always written before use.
   always_ff @(posedge clk) begin
      instr_q   <= instr_d;
      alu_res_q <= alu_res_d;
      next_pc_q <= next_pc_d;
      load_q    <= load_d;
      dwb_adr_q <= dwb_adr_d;
      dwb_dat_q <= dwb_dat_d;
   end

   assign iwb_adr_o = pc_q;
   assign iwb_cyc_o = iwb_cyc_q;
   assign iwb_stb_o = iwb_cyc_q;
   assign dwb_adr_o = dwb_adr_q;
   assign dwb_dat_o = dwb_dat_q;
   assign dwb_we_o  = dwb_we_q;
   assign dwb_sel_o = dwb_sel_q;
   assign dwb_cyc_o = dwb_cyc_q;
   assign dwb_stb_o = dwb_cyc_q;
endmodule

// File: tb/tb_custom_rv_core.sv
// Directed-program bench for custom_rv_core: bus responders, an expected-event scoreboard
// fed per program, and a monitor that checks register writebacks and stores as they appear.
module tb_custom_rv_core;
   localparam logic [6:0] OPIMM = 7'b0010011, LOAD = 7'b0000011, JALR = 7'b1100111,
                          LUI = 7'b0110111;

   logic        clk, rst_n;
   logic [31:0] iwb_adr_o, iwb_dat_i, dwb_adr_o, dwb_dat_o, dwb_dat_i, interrupts;
   logic        iwb_cyc_o, iwb_stb_o, iwb_ack_i, dwb_we_o, dwb_cyc_o, dwb_stb_o;
   logic        dwb_ack_i, dwb_err_i;
   logic [3:0]  dwb_sel_o;

   logic [31:0] imem [0:63];
   logic [31:0] dmem [0:63];
   logic        istall, err_en;
   int          ip, tests, fails;

   typedef struct {
      bit          st;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ev_t;
   ev_t exp_q[$];

   custom_rv_core #(.RESET_VECTOR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .iwb_adr_o(iwb_adr_o), .iwb_dat_i(iwb_dat_i), .iwb_cyc_o(iwb_cyc_o),
      .iwb_stb_o(iwb_stb_o), .iwb_ack_i(iwb_ack_i),
      .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_dat_i(dwb_dat_i),
      .dwb_we_o(dwb_we_o), .dwb_sel_o(dwb_sel_o), .dwb_cyc_o(dwb_cyc_o),
      .dwb_stb_o(dwb_stb_o), .dwb_ack_i(dwb_ack_i), .dwb_err_i(dwb_err_i),
      .interrupts(interrupts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memories answer 2 ns after each rising edge while a cycle is open.
   always @(posedge clk) begin
      #2;
      iwb_ack_i = iwb_cyc_o & iwb_stb_o & !istall;
      iwb_dat_i = imem[iwb_adr_o[7:2]];
      dwb_ack_i = dwb_cyc_o & dwb_stb_o & !err_en;
      dwb_err_i = dwb_cyc_o & dwb_stb_o & err_en;
      dwb_dat_i = dmem[dwb_adr_o[7:2]];
      if (dwb_ack_i && dwb_we_o)
         for (int b = 0; b < 4; b++)
            if (dwb_sel_o[b]) dmem[dwb_adr_o[7:2]][8*b +: 8] = dwb_dat_o[8*b +: 8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_ev(input bit st, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      ev_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL sb_unexpected kind=%0d a=%h d=%h required=no event", st, a, d);
      end else begin
         e = exp_q.pop_front();
         chk(st ? "sb_store_kind" : "sb_wb_kind", {31'd0, st}, {31'd0, e.st});
         chk(st ? "sb_store_addr" : "sb_wb_rd", a, e.a);
         chk(st ? "sb_store_data" : "sb_wb_data", d, e.d);
         if (st) chk("sb_store_sel", {28'd0, s}, {28'd0, e.s});
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dut.state == 3'd4 && dut.rd_wen && dut.rd_addr != 5'd0)
            check_ev(1'b0, {27'd0, dut.rd_addr}, dut.rd_data, 4'd0);
         if (dwb_cyc_o && dwb_we_o && dwb_ack_i)
            check_ev(1'b1, dwb_adr_o, dwb_dat_o, dwb_sel_o);
      end
   end

   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic emit(input logic [31:0] w);
      imem[ip] = w;
      ip++;
   endtask
   task automatic exp_wb(input logic [4:0] rd, input logic [31:0] d);
      exp_q.push_back('{st: 1'b0, a: {27'd0, rd}, d: d, s: 4'd0});
   endtask
   task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_q.push_back('{st: 1'b1, a: a, d: d, s: s});
   endtask

   task automatic start_prog();
      rst_n = 1'b0;
      for (int i = 0; i < 64; i++) begin
         imem[i] = 32'h00000013;
         dmem[i] = 32'h0;
      end
      exp_q.delete();
      ip = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_iwb_cyc", {31'd0, iwb_cyc_o}, 32'd0);
      chk("rst_iwb_stb", {31'd0, iwb_stb_o}, 32'd0);
      chk("rst_dwb_cyc", {31'd0, dwb_cyc_o | dwb_stb_o}, 32'd0);
      chk("rst_dwb_we_sel", {27'd0, dwb_we_o, dwb_sel_o}, 32'd0);
      chk("rst_pc", dut.pc, 32'h0);
      chk("rst_state", {29'd0, dut.state}, 32'd0);
      chk("rst_x1", dut.regfile_inst.registers[1], 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic wait_pc(input logic [31:0] target, input string name);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 600 && !hit; n++) begin
         @(negedge clk);
         if (dut.pc == target && dut.state == 3'd0) hit = 1'b1;
      end
      chk({name, "_reach_timeout"}, {31'd0, hit}, 32'd1);
      repeat (30) @(negedge clk);
      chk({name, "_pc_hold"}, dut.pc, target);
      chk({name, "_events_left"}, exp_q.size(), 32'd0);
   endtask

   function automatic logic [31:0] xr(input int i);
      return dut.regfile_inst.registers[i];
   endfunction

   initial begin
      bit seen;
      tests = 0; fails = 0;
      rst_n = 1'b0; istall = 1'b0; err_en = 1'b0;
      interrupts = 32'hDEADBEEF;

      // Program 1: shifts by register amount, ends in jal x0,0 at 0x18.
      start_prog();
      emit(i_t(12'd8, 0, 3'b000, 1, OPIMM));
      emit(i_t(12'd4, 0, 3'b000, 2, OPIMM));
      emit(r_t(7'h00, 1, 1, 3'b001, 3));
      emit(r_t(7'h00, 1, 2, 3'b001, 4));
      emit(r_t(7'h00, 1, 1, 3'b101, 5));
      emit(r_t(7'h20, 1, 1, 3'b101, 6));
      emit(j_t(21'd0, 0));
      exp_wb(1, 32'd8); exp_wb(2, 32'd4); exp_wb(3, 32'h800);
      exp_wb(4, 32'h400); exp_wb(5, 32'd0); exp_wb(6, 32'd0);
      do_reset();
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (iwb_cyc_o) seen = 1'b1;
      end
      chk("first_fetch_cyc", {31'd0, seen}, 32'd1);
      chk("first_fetch_adr", iwb_adr_o, 32'h0);
      chk("first_fetch_stb", {31'd0, iwb_stb_o}, 32'd1);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         if (iwb_ack_i) seen = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      chk("state_after_ack", {29'd0, dut.state}, 32'd1);
      wait_pc(32'h18, "p1");
      chk("p1_x3", xr(3), 32'h800);
      chk("p1_x4", xr(4), 32'h400);

      // Program 2: arithmetic shifts, immediate shifts, compare, sub, xori.
      start_prog();
      emit({20'h80000, 5'd1, LUI});
      emit(i_t(12'd4, 0, 3'b000, 2, OPIMM));
      emit(r_t(7'h20, 2, 1, 3'b101, 3));
      emit(r_t(7'h00, 2, 1, 3'b101, 4));
      emit(i_t(12'd1, 0, 3'b000, 5, OPIMM));
      emit(i_t(12'h01F, 5, 3'b001, 6, OPIMM));
      emit(i_t(12'h404, 1, 3'b101, 7, OPIMM));
      emit(r_t(7'h20, 5, 2, 3'b000, 8));
      emit(r_t(7'h00, 2, 1, 3'b010, 9));
      emit(r_t(7'h00, 2, 1, 3'b011, 10));
      emit(i_t(12'hFFF, 2, 3'b100, 11, OPIMM));
      emit(j_t(21'd0, 0));
      exp_wb(1, 32'h80000000); exp_wb(2, 32'd4); exp_wb(3, 32'hF8000000);
      exp_wb(4, 32'h08000000); exp_wb(5, 32'd1); exp_wb(6, 32'h80000000);
      exp_wb(7, 32'hF8000000); exp_wb(8, 32'd3); exp_wb(9, 32'd1);
      exp_wb(10, 32'd0); exp_wb(11, 32'hFFFFFFFB);
      do_reset();
      wait_pc(32'h2C, "p2");

      // Program 3: word/byte/half stores and loads around 0x40.
      start_prog();
      emit({20'h11223, 5'd1, LUI});
      emit(i_t(12'h344, 1, 3'b000, 1, OPIMM));
      emit(i_t(12'h040, 0, 3'b000, 2, OPIMM));
      emit(s_t(12'd0, 1, 2, 3'b010));
      emit(i_t(12'd3, 2, 3'b000, 3, LOAD));
      emit(i_t(12'd0, 2, 3'b100, 4, LOAD));
      emit(i_t(12'h0AB, 0, 3'b000, 5, OPIMM));
      emit(s_t(12'd1, 5, 2, 3'b000));
      emit(i_t(12'd0, 2, 3'b010, 6, LOAD));
      emit(i_t(12'd2, 2, 3'b001, 7, LOAD));
      emit(i_t(12'd1, 2, 3'b000, 8, LOAD));
      emit(s_t(12'd2, 5, 2, 3'b001));
      emit(i_t(12'd2, 2, 3'b101, 9, LOAD));
      emit(j_t(21'd0, 0));
      exp_wb(1, 32'h11223000); exp_wb(1, 32'h11223344); exp_wb(2, 32'h40);
      exp_st(32'h40, 32'h11223344, 4'b1111);
      exp_wb(3, 32'h00000011); exp_wb(4, 32'h00000044); exp_wb(5, 32'h000000AB);
      exp_st(32'h41, 32'hABABABAB, 4'b0010);
      exp_wb(6, 32'h1122AB44); exp_wb(7, 32'h00001122); exp_wb(8, 32'hFFFFFFAB);
      exp_st(32'h42, 32'h00AB00AB, 4'b1100);
      exp_wb(9, 32'h000000AB);
      do_reset();
      wait_pc(32'h34, "p3");
      chk("p3_mem_word", dmem[16], 32'h00ABAB44);

      // Program 4: branches, jal/jalr link and target, x0 write, SYSTEM as NOP.
      start_prog();
      emit(i_t(12'd5, 0, 3'b000, 1, OPIMM));
      emit(i_t(12'd5, 0, 3'b000, 2, OPIMM));
      emit(b_t(13'd8, 2, 1, 3'b000));
      emit(i_t(12'd1, 0, 3'b000, 3, OPIMM));
      emit(b_t(13'd8, 2, 1, 3'b001));
      emit(i_t(12'd2, 0, 3'b000, 4, OPIMM));
      emit(j_t(21'd8, 5));
      emit(i_t(12'd3, 0, 3'b000, 6, OPIMM));
      emit(i_t(12'h031, 0, 3'b000, 7, OPIMM));
      emit(i_t(12'd0, 7, 3'b000, 8, JALR));
      emit(i_t(12'd9, 0, 3'b000, 9, OPIMM));
      emit(i_t(12'd9, 0, 3'b000, 9, OPIMM));
      emit(i_t(12'd7, 0, 3'b000, 0, OPIMM));
      emit(r_t(7'h00, 0, 0, 3'b000, 10));
      emit(b_t(13'd8, 2, 1, 3'b101));
      emit(i_t(12'd1, 0, 3'b000, 11, OPIMM));
      emit(32'h00000073);
      emit(j_t(21'd0, 0));
      exp_wb(1, 32'd5); exp_wb(2, 32'd5); exp_wb(4, 32'd2); exp_wb(5, 32'h1C);
      exp_wb(7, 32'h31); exp_wb(8, 32'h28); exp_wb(10, 32'd0);
      do_reset();
      wait_pc(32'h44, "p4");
      chk("p4_x0", xr(0), 32'd0);
      chk("p4_skipped_x3_x6_x9_x11", xr(3) | xr(6) | xr(9) | xr(11), 32'd0);

      // Program 5: load that takes a bus error leaves rd intact.
      start_prog();
      err_en = 1'b1;
      emit(i_t(12'h040, 0, 3'b000, 1, OPIMM));
      emit(i_t(12'h055, 0, 3'b000, 3, OPIMM));
      emit(i_t(12'd0, 1, 3'b010, 3, LOAD));
      emit(i_t(12'd1, 0, 3'b000, 4, OPIMM));
      emit(j_t(21'd0, 0));
      dmem[16] = 32'h12345678;
      exp_wb(1, 32'h40); exp_wb(3, 32'h55); exp_wb(4, 32'd1);
      do_reset();
      wait_pc(32'h10, "p5");
      chk("p5_err_x3", xr(3), 32'h55);

      // Reset while a fetch is held open.
      istall = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (iwb_cyc_o) seen = 1'b1;
      end
      chk("midrst_fetch_open", {31'd0, seen}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_cyc_stb", {30'd0, iwb_cyc_o, iwb_stb_o}, 32'd0);
      chk("midrst_pc", dut.pc, 32'h0);
      chk("midrst_state", {29'd0, dut.state}, 32'd0);
      istall = 1'b0;
      err_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
